// File: rtl/polyz_packer_if.sv
// Bus bundle for the polyz packer: input capture strobe/coefficients and packed result.
// The slave side (packer) consumes in_valid/a_in and produces out_valid/r_out.
// No ready signals: the packer accepts one polynomial every cycle.
interface polyz_packer_if #(
   parameter int N = 256
);
   localparam int AW = 32 * N;   // 256 x 32-bit signed coefficients
   localparam int RW = 20 * N;   // 256 x 20-bit packed fields (640 bytes)

   logic          in_valid;
   logic [AW-1:0] a_in;
   logic          out_valid;
   logic [RW-1:0] r_out;

   // Driver of coefficients, receiver of packed bytes
   modport master (
      output in_valid,
      output a_in,
      input  out_valid,
      input  r_out
   );

   // The packer itself
   modport slave (
      input  in_valid,
      input  a_in,
      output out_valid,
      output r_out
   );
endinterface

// File: rtl/polyz_packer.sv
// Packs 256 signed z coefficients into the 640-byte GAMMA1=2^19 bit stream (20 bits each).
// Latency 1 cycle: combinational pack, then one output register with a valid pulse.
// No backpressure: a new polynomial can be captured every cycle; r_out holds when idle.
module polyz_packer #(
   parameter int N = 256
) (
   input  logic           clk,
   input  logic           rst,
   polyz_packer_if.slave  bus
);
   localparam int          RW     = 20 * N;
   localparam logic [19:0] GAMMA1 = 20'h80000;

   logic [RW-1:0] pack_c;
   logic [RW-1:0] r_d, r_q;
   logic          vld_d, vld_q;

   // Per coefficient: t = (GAMMA1 - a) mod 2^20. Only the low 20 bits of a can affect
   // the low 20 bits of the difference, so the subtraction is done at 20 bits. Fields
   // sit back to back, which is exactly the little-endian byte stream of the reference.
   always_comb begin
      pack_c = '0;
      for (int i = 0; i < N; i++) begin
         pack_c[20*i +: 20] = GAMMA1 - bus.a_in[32*i +: 20];
      end
   end

   // Next state: capture on in_valid, otherwise hold data and drop the valid pulse
   always_comb begin
      r_d   = r_q;
      vld_d = 1'b0;
      if (bus.in_valid) begin
         r_d   = pack_c;
         vld_d = 1'b1;
      end
   end

   // Output register; reset wins over a coincident capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         vld_q <= vld_d;
      end
   end

   assign bus.r_out     = r_q;
   assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_polyz_packer.sv
module tb_polyz_packer;
   localparam int N  = 256;
   localparam int AW = 32 * N;
   localparam int RW = 20 * N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   polyz_packer_if #(.N(N)) bus ();

   polyz_packer #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   bit done     = 1'b0;

   logic [RW-1:0] exp_q[$];

   // Reference byte-oriented packer: groups of 4 coefficients -> 10 bytes
   function automatic logic [RW-1:0] pack_model(input logic [AW-1:0] a);
      logic [RW-1:0] r;
      logic [31:0]   c;
      logic [19:0]   t [4];
      r = '0;
      for (int j = 0; j < N/4; j++) begin
         for (int k = 0; k < 4; k++) begin
            c    = a[32*(4*j+k) +: 32];
            t[k] = 20'(32'h0008_0000 - c);
         end
         r[8*(10*j+0) +: 8] = t[0][7:0];
         r[8*(10*j+1) +: 8] = t[0][15:8];
         r[8*(10*j+2) +: 8] = {t[1][3:0], t[0][19:16]};
         r[8*(10*j+3) +: 8] = t[1][11:4];
         r[8*(10*j+4) +: 8] = t[1][19:12];
         r[8*(10*j+5) +: 8] = t[2][7:0];
         r[8*(10*j+6) +: 8] = t[2][15:8];
         r[8*(10*j+7) +: 8] = {t[3][3:0], t[2][19:16]};
         r[8*(10*j+8) +: 8] = t[3][11:4];
         r[8*(10*j+9) +: 8] = t[3][19:12];
      end
      return r;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Compare two full 640-byte results; report the first differing byte only
   task automatic check_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      int bad;
      bad = -1;
      checks++;
      for (int k = RW/8 - 1; k >= 0; k--) begin
         if (act[8*k +: 8] !== exp[8*k +: 8]) bad = k;
      end
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s byte=%0d actual=0x%0h required=0x%0h",
                  name, bad, act[8*bad +: 8], exp[8*bad +: 8]);
      end
   endtask

   // Monitor: every out_valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!done && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid actual=1 required=0");
         end else begin
            check_vec("scoreboard", bus.r_out, exp_q.pop_front());
         end
      end
   end

   // Drive a capture; returns just after the capturing edge with in_valid still high
   task automatic send(input logic [AW-1:0] a, input logic [RW-1:0] exp);
      bus.in_valid = 1'b1;
      bus.a_in     = a;
      exp_q.push_back(exp);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [AW-1:0] rand_vec();
      logic [AW-1:0] v;
      for (int i = 0; i < N; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] v, v1, v2, v3;
      logic [RW-1:0] e;
      logic [19:0]   bnd_a [4];
      logic [19:0]   bnd_t [4];
      logic [39:0]   grp;
      logic [7:0]    hb [6];

      bus.in_valid = 1'b0;
      bus.a_in     = '0;

      // 1. Reset with in_valid and random data: outputs stay cleared
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         bus.a_in = rand_vec();
         @(posedge clk); #1;
         check32("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
         check_vec("reset_r_out", bus.r_out, '0);
      end
      bus.in_valid = 1'b0;
      rst = 1'b0;
      idle(1);
      check32("post_reset_out_valid", {31'b0, bus.out_valid}, 32'd0);

      // 2. All-zero input: bytes 00 00 08 00 80 repeated
      grp = 40'h80_00_08_00_00;
      for (int j = 0; j < N/2; j++) e[40*j +: 40] = grp;
      send('0, e);
      idle(1);

      // 3. a1=-77, a2=246, rest 0
      v = '0;
      v[32*1 +: 32] = 32'hFFFF_FFB3;
      v[32*2 +: 32] = 32'h0000_00F6;
      send(v, pack_model(v));
      bus.in_valid = 1'b0;
      hb = '{8'h00, 8'h00, 8'hD8, 8'h04, 8'h80, 8'h0A};
      for (int k = 0; k < 6; k++) check32($sformatf("hand_byte%0d", k), {24'b0, bus.r_out[8*k +: 8]}, {24'b0, hb[k]});

      // Hold: a_in changes while idle must not reach r_out
      e = bus.r_out;
      bus.a_in = rand_vec();
      idle(2);
      check32("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_vec("idle_hold", bus.r_out, pack_model(v));

      // 4. Boundaries placed in coefficient 255
      bnd_a = '{20'h80000, 20'h80001, 20'h00001, 20'hFFFFF};
      bnd_t = '{20'h00000, 20'hFFFFF, 20'h7FFFF, 20'h80001};
      for (int b = 0; b < 4; b++) begin
         v = '0;
         v[32*255 +: 32] = {{12{bnd_a[b][19]}}, bnd_a[b]};
         if (b == 0) v[32*255 +: 32] = 32'h0008_0000;
         send(v, pack_model(v));
         bus.in_valid = 1'b0;
         check32($sformatf("boundary%0d_top", b), {12'b0, bus.r_out[RW-1 -: 20]}, {12'b0, bnd_t[b]});
      end
      idle(1);

      // 5. Alternating ramp against the model
      for (int k = 0; k < N/2; k++) begin
         v[32*(2*k)   +: 32] = 32'(246 * k);
         v[32*(2*k+1) +: 32] = -32'(77 + 154 * k);
      end
      send(v, pack_model(v));
      idle(1);

      // 6. Three back-to-back captures then idle
      v1 = rand_vec();
      v2 = rand_vec();
      v3 = rand_vec();
      send(v1, pack_model(v1));
      send(v2, pack_model(v2));
      send(v3, pack_model(v3));
      idle(3);
      check32("stream_out_valid_after", {31'b0, bus.out_valid}, 32'd0);
      check_vec("stream_hold_third", bus.r_out, pack_model(v3));

      // Reset mid-stream: coincident capture is discarded
      bus.in_valid = 1'b1;
      bus.a_in     = rand_vec();
      rst          = 1'b1;
      @(posedge clk); #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check32("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_vec("midreset_r_out", bus.r_out, '0);
      idle(2);

      @(posedge clk); #1;
      done = 1'b1;
      check32("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
